// File: rtl/field_word_builder_pkg.sv
// Shared constants, types and slot-position helper for the field word builder
// and its receive-side field-select mux.
package field_word_builder_pkg;

    localparam int unsigned FIELD_W  = 3;
    localparam int unsigned SLOT_CNT = 4;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned SEQ_W    = 2;
    localparam int unsigned WORD_W   = 16;

    typedef logic [FIELD_W-1:0]          field_t;
    typedef logic [SLOT_CNT*FIELD_W-1:0] slots_t;
    typedef logic [WORD_W-1:0]           word_t;

    // LSB position of slot k inside the packed word; the select code sits below slot 0.
    function automatic int unsigned slot_lsb(input int unsigned k);
        return FIELD_W * k + SEL_W;
    endfunction

endpackage

// File: rtl/field_bank.sv
// Four slot registers plus filled mask, with same-cycle write forwarding and
// optional clear on an accepted emit.
module field_bank
    import field_word_builder_pkg::*;
#(
    parameter bit CLEAR_ON_EMIT = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_valid_i,
    input  logic [1:0]          wr_slot_i,
    input  field_t              wr_data_i,
    input  logic                clear_i,
    output slots_t              fields_o,
    output logic [SLOT_CNT-1:0] filled_o
);

    field_t              slot_q [SLOT_CNT];
    field_t              slot_d [SLOT_CNT];
    logic [SLOT_CNT-1:0] filled_q;
    logic [SLOT_CNT-1:0] filled_d;

    // Forwarded view: a same-cycle write overrides the stored field.
    always_comb begin
        fields_o = '0;
        for (int k = 0; k < SLOT_CNT; k++) begin
            if (wr_valid_i && (wr_slot_i == 2'(k))) begin
                fields_o[k*FIELD_W +: FIELD_W] = wr_data_i;
            end else begin
                fields_o[k*FIELD_W +: FIELD_W] = slot_q[k];
            end
        end
    end

    // Next state: clear first so a same-cycle write still lands afterwards.
    always_comb begin
        slot_d   = slot_q;
        filled_d = filled_q;
        if (CLEAR_ON_EMIT && clear_i) begin
            for (int k = 0; k < SLOT_CNT; k++) begin
                slot_d[k] = '0;
            end
            filled_d = '0;
        end
        if (wr_valid_i) begin
            slot_d[wr_slot_i]   = wr_data_i;
            filled_d[wr_slot_i] = 1'b1;
        end
    end

    // Slot and filled-mask registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < SLOT_CNT; k++) begin
                slot_q[k] <= '0;
            end
            filled_q <= '0;
        end else begin
            slot_q   <= slot_d;
            filled_q <= filled_d;
        end
    end

    assign filled_o = filled_q;

endmodule

// File: rtl/field_word_builder.sv
// Packs slot fields, select code and sequence number into a 16-bit word and
// presents it on a one-entry registered valid/ready output.
module field_word_builder
    import field_word_builder_pkg::*;
#(
    parameter bit CLEAR_ON_EMIT = 1'b0,
    parameter bit SEQ_EN        = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_valid,
    input  logic [1:0]          i_wr_slot,
    input  logic [FIELD_W-1:0]  i_wr_data,
    input  logic                i_emit_valid,
    input  logic [SEL_W-1:0]    i_emit_sel,
    output logic                o_emit_ready,
    output logic [WORD_W-1:0]   o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SLOT_CNT-1:0] o_filled
);

    slots_t           fields;
    logic             emit_acc;
    word_t            word_c;
    word_t            data_q, data_d;
    logic             valid_q, valid_d;
    logic [SEQ_W-1:0] seq_q, seq_d;

    field_bank #(
        .CLEAR_ON_EMIT (CLEAR_ON_EMIT)
    ) u_field_bank (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .wr_valid_i (i_wr_valid),
        .wr_slot_i  (i_wr_slot),
        .wr_data_i  (i_wr_data),
        .clear_i    (emit_acc),
        .fields_o   (fields),
        .filled_o   (o_filled)
    );

    // Emit handshake: the output register can take a word when empty or draining.
    always_comb begin
        o_emit_ready = !valid_q || i_ready;
        emit_acc     = i_emit_valid && o_emit_ready;
    end

    // Word assembly from forwarded fields, select code and sequence number.
    always_comb begin
        word_c            = '0;
        word_c[SEL_W-1:0] = i_emit_sel;
        for (int unsigned k = 0; k < SLOT_CNT; k++) begin
            word_c[slot_lsb(k) +: FIELD_W] = fields[k*FIELD_W +: FIELD_W];
        end
        word_c[WORD_W-1 -: SEQ_W] = SEQ_EN ? seq_q : '0;
    end

    // Output register and sequence counter next state.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        seq_d   = seq_q;
        if (emit_acc) begin
            data_d  = word_c;
            valid_d = 1'b1;
            seq_d   = seq_q + 1'b1;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output and sequence registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            seq_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            seq_q   <= seq_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_field_word_builder.sv
// Self-checking bench for field_word_builder: default instance checked against
// a scoreboard model, a CLEAR_ON_EMIT=1 instance checked on the clear scenario.
module tb_field_word_builder;
    import field_word_builder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [1:0]  wr_slot;
    logic [2:0]  wr_data;
    logic        emit_valid;
    logic [1:0]  emit_sel;
    logic        ready;

    logic        emit_ready0, valid0, emit_ready1, valid1;
    logic [15:0] data0, data1;
    logic [3:0]  filled0, filled1;

    int total = 0;
    int bad   = 0;

    // Scoreboard and reference model of the default instance.
    logic [15:0] exp_q[$];
    logic [2:0]  m_slot [4];
    logic [3:0]  m_filled;
    logic [1:0]  m_seq;
    logic        m_valid;

    always #5 clk = ~clk;

    field_word_builder u_dut0 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_valid   (wr_valid),
        .i_wr_slot    (wr_slot),
        .i_wr_data    (wr_data),
        .i_emit_valid (emit_valid),
        .i_emit_sel   (emit_sel),
        .o_emit_ready (emit_ready0),
        .o_data       (data0),
        .o_valid      (valid0),
        .i_ready      (ready),
        .o_filled     (filled0)
    );

    field_word_builder #(
        .CLEAR_ON_EMIT (1'b1),
        .SEQ_EN        (1'b1)
    ) u_dut1 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_valid   (wr_valid),
        .i_wr_slot    (wr_slot),
        .i_wr_data    (wr_data),
        .i_emit_valid (emit_valid),
        .i_emit_sel   (emit_sel),
        .o_emit_ready (emit_ready1),
        .o_data       (data1),
        .o_valid      (valid1),
        .i_ready      (ready),
        .o_filled     (filled1)
    );

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_slot[k] = 3'b000;
        m_filled = 4'b0000;
        m_seq    = 2'b00;
        m_valid  = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model by one cycle using the currently driven inputs.
    task automatic model_step();
        logic [2:0] fwd [4];
        logic       acc;
        for (int k = 0; k < 4; k++) fwd[k] = m_slot[k];
        if (wr_valid) fwd[wr_slot] = wr_data;
        acc = emit_valid && (!m_valid || ready);
        if (acc) begin
            exp_q.push_back({m_seq, fwd[3], fwd[2], fwd[1], fwd[0], emit_sel});
            m_seq = m_seq + 2'b01;
        end
        if (wr_valid) begin
            m_slot[wr_slot]   = wr_data;
            m_filled[wr_slot] = 1'b1;
        end
        if (acc) m_valid = 1'b1;
        else if (ready) m_valid = 1'b0;
    endtask

    task automatic drive(input logic wv, input logic [1:0] ws, input logic [2:0] wd,
                         input logic ev, input logic [1:0] es, input logic rd);
        wr_valid   = wv;
        wr_slot    = ws;
        wr_data    = wd;
        emit_valid = ev;
        emit_sel   = es;
        ready      = rd;
    endtask

    // One clock: update model, then sample 1 time unit after the rising edge.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 1'b1);
        rst = 1'b1;
        model_reset();
        #2;
        total++;
        if (data0 !== 16'h0000) begin
            bad++; $display("FAIL reset_data got=%h want=0000", data0);
        end
        total++;
        if (valid0 !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b want=0", valid0);
        end
        total++;
        if (emit_ready0 !== 1'b1) begin
            bad++; $display("FAIL reset_emit_ready got=%b want=1", emit_ready0);
        end
        total++;
        if (filled0 !== 4'b0000) begin
            bad++; $display("FAIL reset_filled got=%b want=0000", filled0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic_emit();
        logic [15:0] exp;
        logic [2:0]  rx;
        drive(1'b1, 2'd0, 3'b101, 1'b0, 2'd0, 1'b1);
        step();
        drive(1'b1, 2'd2, 3'b011, 1'b0, 2'd0, 1'b1);
        step();
        drive(1'b0, 2'd0, 3'd0, 1'b1, 2'b10, 1'b0);
        step();
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 1'b0);
        exp = exp_q.pop_front();
        total++;
        if (data0 !== exp) begin
            bad++; $display("FAIL basic_data got=%h want=%h", data0, exp);
        end
        total++;
        if (valid0 !== 1'b1) begin
            bad++; $display("FAIL basic_valid got=%b want=1", valid0);
        end
        total++;
        if (filled0 !== 4'b0101) begin
            bad++; $display("FAIL basic_filled got=%b want=0101", filled0);
        end
        rx = data0[slot_lsb(int'(data0[1:0])) +: 3];
        total++;
        if (rx !== 3'b011) begin
            bad++; $display("FAIL basic_rx_field got=%b want=011", rx);
        end
    endtask

    task automatic test_stall();
        logic [15:0] held;
        logic [15:0] exp;
        held = 16'h0316;
        drive(1'b0, 2'd0, 3'd0, 1'b1, 2'b11, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (emit_ready0 !== 1'b0) begin
                bad++; $display("FAIL stall_emit_ready c=%0d got=%b want=0", c, emit_ready0);
            end
            step();
            total++;
            if (data0 !== held || valid0 !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold c=%0d got=%h/%b want=%h/1", c, data0, valid0, held);
            end
        end
        ready = 1'b1;
        #1;
        total++;
        if (emit_ready0 !== 1'b1) begin
            bad++; $display("FAIL stall_release_ready got=%b want=1", emit_ready0);
        end
        step();
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 1'b1);
        exp = exp_q.pop_front();
        total++;
        if (data0 !== exp || valid0 !== 1'b1) begin
            bad++; $display("FAIL stall_release_data got=%h/%b want=%h/1", data0, valid0, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        logic [1:0]  seqs [5];
        seqs = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2'd0, 3'd0, 1'b1, 2'(i), 1'b1);
            step();
            exp = exp_q.pop_front();
            total++;
            if (data0 !== exp || valid0 !== 1'b1) begin
                bad++; $display("FAIL b2b_data i=%0d got=%h want=%h", i, data0, exp);
            end
            total++;
            if (data0[15:14] !== seqs[i]) begin
                bad++; $display("FAIL b2b_seq i=%0d got=%0d want=%0d", i, data0[15:14], seqs[i]);
            end
        end
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 1'b1);
        step();
        total++;
        if (valid0 !== 1'b0) begin
            bad++; $display("FAIL b2b_drain got=%b want=0", valid0);
        end
    endtask

    task automatic test_same_cycle_write();
        logic [15:0] exp;
        apply_reset();
        drive(1'b1, 2'd0, 3'b101, 1'b0, 2'd0, 1'b1);
        step();
        drive(1'b1, 2'd3, 3'b010, 1'b0, 2'd0, 1'b1);
        step();
        drive(1'b1, 2'd1, 3'b111, 1'b1, 2'b01, 1'b1);
        step();
        exp = exp_q.pop_front();
        total++;
        if (data0 !== exp) begin
            bad++; $display("FAIL fwd_data got=%h want=%h", data0, exp);
        end
        total++;
        if (data0[7:5] !== 3'b111) begin
            bad++; $display("FAIL fwd_slot1 got=%b want=111", data0[7:5]);
        end
        total++;
        if (filled0 !== 4'b1011) begin
            bad++; $display("FAIL fwd_filled got=%b want=1011", filled0);
        end
        total++;
        if (data1 !== 16'h10F5) begin
            bad++; $display("FAIL clr_data got=%h want=10f5", data1);
        end
        total++;
        if (filled1 !== 4'b0010) begin
            bad++; $display("FAIL clr_filled got=%b want=0010", filled1);
        end
        drive(1'b0, 2'd0, 3'd0, 1'b1, 2'b00, 1'b1);
        step();
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 1'b1);
        exp = exp_q.pop_front();
        total++;
        if (data0 !== exp) begin
            bad++; $display("FAIL noclr_second got=%h want=%h", data0, exp);
        end
        total++;
        if (data1 !== 16'h40E0) begin
            bad++; $display("FAIL clr_second got=%h want=40e0", data1);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] exp;
        apply_reset();
        drive(1'b1, 2'd2, 3'b110, 1'b1, 2'b10, 1'b0);
        step();
        drive(1'b0, 2'd0, 3'd0, 1'b1, 2'b00, 1'b0);
        step();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (valid0 !== 1'b0) begin
            bad++; $display("FAIL async_rst_valid got=%b want=0", valid0);
        end
        total++;
        if (data0 !== 16'h0000) begin
            bad++; $display("FAIL async_rst_data got=%h want=0000", data0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive(1'b1, 2'd3, 3'b001, 1'b1, 2'b11, 1'b1);
        step();
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 1'b1);
        exp = exp_q.pop_front();
        total++;
        if (data0 !== exp || valid0 !== 1'b1) begin
            bad++; $display("FAIL post_rst_data got=%h/%b want=%h/1", data0, valid0, exp);
        end
        total++;
        if (data0[15:14] !== 2'b00) begin
            bad++; $display("FAIL post_rst_seq got=%0d want=0", data0[15:14]);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 1'b1);
        test_reset();
        test_basic_emit();
        test_stall();
        test_back_to_back();
        test_same_cycle_write();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
